// File: rtl/fifo_frame_reader.sv
// Purpose: drains a first-word-fall-through FIFO into fixed-length frames on a registered valid/ready stream.
// Latency: one cycle from a FIFO head word to m_valid when the output register is free.
// Backpressure: m_ready=0 with m_valid=1 stops popping and holds data/index/sof/eof stable.
module fifo_frame_reader #(
    parameter int DSIZE     = 16,
    parameter int FRAME_LEN = 256,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flush,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sof,
    output logic             m_eof,
    output logic [IDX_W-1:0] m_index,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // One output beat: sample plus its framing side-band.
    typedef struct packed {
        logic [DSIZE-1:0] dat;
        logic [IDX_W-1:0] index;
        logic             sof;
        logic             eof;
    } beat_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    beat_t            beat_q, beat_d;
    logic             m_valid_q, m_valid_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [15:0]      stall_count_q, stall_count_d;

    // A flush pulse seen while already purging is ignored.
    logic flush_req;
    // Output register can take a new word this cycle.
    logic out_free;
    // A sample is popped into the output register this cycle.
    logic pop_run;
    // Downstream takes the held beat this cycle.
    logic accept;

    assign flush_req = flush && (state_q != ST_FLUSH);
    assign out_free  = !m_valid_q || m_ready;
    assign pop_run   = (state_q == ST_RUN) && !flush_req && !fifo_rempty && out_free;
    assign accept    = m_valid_q && m_ready;

    // Next-state, sample index and FIFO pop; flush overrides everything else.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fifo_rinc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fifo_rinc = pop_run;
                if (pop_run) begin
                    if (idx_q == IDX_LAST) begin
                        // Frame boundary: the only point where enable is honoured.
                        idx_d = '0;
                        if (!enable) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                fifo_rinc = !fifo_rempty;
                if (fifo_rempty) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush_req) begin
            state_d   = ST_FLUSH;
            idx_d     = '0;
            fifo_rinc = 1'b0;
        end
    end

    // Output register: load on pop, empty on accept without refill, drop on flush.
    always_comb begin
        beat_d    = beat_q;
        m_valid_d = m_valid_q;
        if (pop_run) begin
            beat_d.dat   = fifo_rdata;
            beat_d.index = idx_q;
            beat_d.sof   = (idx_q == '0);
            beat_d.eof   = (idx_q == IDX_LAST);
            m_valid_d    = 1'b1;
        end else if (accept) begin
            m_valid_d = 1'b0;
        end
        if (flush_req) begin
            m_valid_d = 1'b0;
        end
    end

    // Status counters: completed frames wrap, mid-frame starvation saturates.
    always_comb begin
        frame_count_d = frame_count_q;
        stall_count_d = stall_count_q;
        if (accept && beat_q.eof) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        if ((state_q == ST_RUN) && (idx_q != '0) && fifo_rempty && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            beat_q        <= '0;
            m_valid_q     <= 1'b0;
            frame_count_q <= 16'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            beat_q        <= beat_d;
            m_valid_q     <= m_valid_d;
            frame_count_q <= frame_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign m_data      = beat_q.dat;
    assign m_index     = beat_q.index;
    assign m_sof       = beat_q.sof;
    assign m_eof       = beat_q.eof;
    assign m_valid     = m_valid_q;
    assign busy        = (state_q != ST_IDLE) || m_valid_q;
    assign frame_count = frame_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Purpose: directed scoreboard bench for fifo_frame_reader with a queue-based FWFT FIFO model.
// Latency: expects first beat one cycle after the first RUN pop.
// Backpressure: drives m_ready patterns and checks held outputs stay stable.
module tb_fifo_frame_reader;

    localparam int DSIZE     = 16;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 2;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             sof;
        logic             eof;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             flush;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_sof;
    logic             m_eof;
    logic [IDX_W-1:0] m_index;
    logic             busy;
    logic [15:0]      frame_count;
    logic [15:0]      stall_count;

    fifo_frame_reader #(
        .DSIZE     (DSIZE),
        .FRAME_LEN (FRAME_LEN),
        .IDX_W     (IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .flush       (flush),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eof       (m_eof),
        .m_index     (m_index),
        .busy        (busy),
        .frame_count (frame_count),
        .stall_count (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               errors = 0;
    int               checks = 0;
    logic [DSIZE-1:0] fifo_q[$];
    beat_t            exp_q[$];
    int               exp_frames = 0;
    logic             last_rinc = 1'b0;
    logic             hold_vld = 1'b0;
    beat_t            hold_beat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fifo_sync();
        fifo_rempty = (fifo_q.size() == 0);
        fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [DSIZE-1:0] d);
        fifo_q.push_back(d);
        fifo_sync();
    endtask

    task automatic push_exp(input logic [DSIZE-1:0] d, input int idx);
        beat_t b;
        b.data = d;
        b.idx  = IDX_W'(idx);
        b.sof  = (idx == 0);
        b.eof  = (idx == FRAME_LEN - 1);
        exp_q.push_back(b);
    endtask

    // One clock: sample pre-edge handshakes, score accepted beats, advance the FIFO model.
    task automatic tick();
        beat_t            obs;
        beat_t            e;
        logic [DSIZE-1:0] dummy;
        #1;
        last_rinc = fifo_rinc;
        obs = {m_data, m_index, m_sof, m_eof};
        if (hold_vld) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_beat", 32'(obs), 32'(hold_beat));
        end
        hold_vld  = m_valid && !m_ready && !flush;
        hold_beat = obs;
        if (m_valid && m_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_data), 32'(e.data));
                chk("beat_index", 32'(m_index), 32'(e.idx));
                chk("beat_sof", 32'(m_sof), 32'(e.sof));
                chk("beat_eof", 32'(m_eof), 32'(e.eof));
                if (e.eof) exp_frames++;
            end
        end
        if (last_rinc) chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
        @(posedge clk);
        #1;
        if (last_rinc && fifo_q.size() != 0) dummy = fifo_q.pop_front();
        fifo_sync();
    endtask

    task automatic drain(input string tag, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_flush(output int rinc_cnt);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_drops_valid", 32'(m_valid), 32'd0);
        rinc_cnt = 0;
        for (int n = 0; n < 30 && busy; n++) begin
            tick();
            if (last_rinc) rinc_cnt++;
        end
        chk("flush_done_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int          n;
        int          pops;
        int          cnt;
        logic [15:0] stall_base;

        rst_n   = 1'b0;
        enable  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        fifo_sync();
        #2;
        // Reset state, before any clock edge.
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_flags", 32'({m_sof, m_eof, m_index}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_counts", {frame_count, stall_count}, 32'd0);
        chk("rst_rinc", 32'(fifo_rinc), 32'd0);
        #20;
        rst_n = 1'b1;

        // Two back-to-back frames at full rate.
        for (int i = 0; i < 8; i++) begin
            push_word(DSIZE'(16'h10 + i));
            push_exp(DSIZE'(16'h10 + i), i % FRAME_LEN);
        end
        enable = 1'b1;
        drain("t1_drain", n);
        chk("t1_cycles", 32'(n), 32'd10);
        chk("t1_frames", 32'(frame_count), 32'(exp_frames));
        chk("t1_frames_abs", 32'(frame_count), 32'd2);

        // Same stream with m_ready toggling every cycle.
        for (int i = 0; i < 8; i++) begin
            push_word(DSIZE'(16'h20 + i));
            push_exp(DSIZE'(16'h20 + i), i % FRAME_LEN);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            m_ready = ~m_ready;
            n++;
        end
        chk("t2_drain", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
        tick();
        chk("t2_fifo_empty", 32'(fifo_q.size()), 32'd0);
        chk("t2_frames", 32'(frame_count), 32'(exp_frames));

        // enable dropped mid-frame: the frame completes, then reader idles.
        for (int i = 0; i < 8; i++) begin
            push_word(DSIZE'(16'h30 + i));
            if (i < 4) push_exp(DSIZE'(16'h30 + i), i);
        end
        pops = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            if (last_rinc) pops++;
            if (pops >= 2) enable = 1'b0;
            n++;
        end
        chk("t3_drain", 32'(exp_q.size()), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t3_fifo_left", 32'(fifo_q.size()), 32'd4);
        chk("t3_frames", 32'(frame_count), 32'(exp_frames));
        do_flush(cnt);
        chk("t3_purge_pops", 32'(cnt), 32'd4);

        // Mid-frame starvation for five cycles at idx 2.
        stall_base = stall_count;
        enable = 1'b1;
        push_word(16'h0040);
        push_exp(16'h0040, 0);
        push_word(16'h0041);
        push_exp(16'h0041, 1);
        pops = 0;
        n = 0;
        while (pops < 2 && n < 20) begin
            tick();
            if (last_rinc) pops++;
            n++;
        end
        chk("t4_pops", 32'(pops), 32'd2);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_stall", 32'(stall_count), 32'(stall_base + 16'd5));
        push_word(16'h0042);
        push_exp(16'h0042, 2);
        push_word(16'h0043);
        push_exp(16'h0043, 3);
        drain("t4_drain", n);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_stall_idx0", 32'(stall_count), 32'(stall_base + 16'd5));
        chk("t4_frames", 32'(frame_count), 32'(exp_frames));

        // Flush while a word is held under backpressure with 3 words queued.
        m_ready = 1'b0;
        push_word(16'h00A0);
        tick();
        chk("t5_held", 32'(m_valid), 32'd1);
        push_word(16'h00A1);
        push_word(16'h00A2);
        push_word(16'h00A3);
        tick();
        tick();
        chk("t5_no_pop_bp", 32'(fifo_q.size()), 32'd3);
        enable = 1'b0;
        flush  = 1'b1;
        #1;
        chk("t5_rinc_flush_cycle", 32'(fifo_rinc), 32'd0);
        do_flush(cnt);
        chk("t5_purge_pops", 32'(cnt), 32'd3);
        chk("t5_fifo_empty", 32'(fifo_q.size()), 32'd0);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_word(DSIZE'(16'h50 + i));
            push_exp(DSIZE'(16'h50 + i), i);
        end
        drain("t5_drain", n);
        chk("t5_frames", 32'(frame_count), 32'(exp_frames));

        // Asynchronous reset mid-frame.
        m_ready = 1'b0;
        push_word(16'h0060);
        push_word(16'h0061);
        tick();
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_data", 32'(m_data), 32'd0);
        chk("t6_rst_flags", 32'({m_sof, m_eof, m_index}), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_counts", {frame_count, stall_count}, 32'd0);
        chk("t6_rst_rinc", 32'(fifo_rinc), 32'd0);
        exp_q.delete();
        hold_vld   = 1'b0;
        exp_frames = 0;
        enable     = 1'b0;
        m_ready    = 1'b1;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_post_busy", 32'(busy), 32'd0);
        chk("t6_post_counts", {frame_count, stall_count}, 32'd0);
        chk("t6_fifo_kept", 32'(fifo_q.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side controller for the dual-clock FIFO; runs entirely in the FIFO read clock domain.
- Drains FIFO samples with first-word fall-through and assembles them into fixed-length frames of FRAME_LEN samples.
- Presents frames on a registered valid/ready stream to the downstream windowing/FFT stage, with start-of-frame and end-of-frame markers.
- Provides frame-aligned start/stop, a flush sequence that purges the FIFO, and status counters.

Parameters:
- DSIZE, 16, sample width; must match the FIFO data width.
- FRAME_LEN, 256, samples per frame; minimum 2.
- IDX_W, $clog2(FRAME_LEN), width of the sample index.

Ports:
- clk  in  1  read-domain clock; same clock as the FIFO read port.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled only at frame boundaries.
- flush  in  1  single-cycle pulse: abort the current frame and purge the FIFO.
- fifo_rdata  in  DSIZE  FIFO head word; valid whenever fifo_rempty=0.
- fifo_rempty  in  1  FIFO empty flag.
- fifo_rinc  out  1  FIFO pop; combinational.
- m_data  out  DSIZE  output sample; registered.
- m_valid  out  1  output valid; registered.
- m_ready  in  1  downstream accept.
- m_sof  out  1  m_data is sample 0 of a frame.
- m_eof  out  1  m_data is sample FRAME_LEN-1 of a frame.
- m_index  out  IDX_W  position of m_data within its frame.
- busy  out  1  state!=IDLE or m_valid=1.
- frame_count  out  16  completed frames; wraps.
- stall_count  out  16  mid-frame starvation cycles; saturates at 16'hFFFF.

Behaviour:
- Reset: state=IDLE, idx=0, and all outputs 0, including m_valid, m_data, m_sof, m_eof, m_index, busy, frame_count and stall_count. fifo_rinc=0.
- States: IDLE, RUN, FLUSH.
- IDLE -> RUN when enable=1 and flush=0. IDLE performs no pops.
- RUN pop rule: fifo_rinc = !fifo_rempty && (!m_valid || m_ready).
- On each pop, the output register loads on the next edge: m_data=fifo_rdata, m_index=idx, m_sof=(idx==0), m_eof=(idx==FRAME_LEN-1), m_valid=1.
- idx increments on each pop and wraps to 0 after FRAME_LEN-1.
- Output register clears (m_valid=0) when m_valid && m_ready and no pop occurs in the same cycle.
- Latency: a word at the FIFO head with the output register empty reaches m_valid one cycle later.
- Throughput: one sample per cycle while the FIFO is non-empty and m_ready=1.
- Frame boundary: on the pop of idx==FRAME_LEN-1, if enable=0 the next state is IDLE; otherwise it stays RUN.
- enable deasserted mid-frame has no effect until that frame's last sample is popped; frames are never truncated by enable.
- The output register keeps draining in IDLE; m_valid stays until accepted.
- Starvation: stall_count increments in each RUN cycle with idx!=0 and fifo_rempty=1.
- flush (any state, highest priority):
  - next edge: m_valid=0 (held word dropped), idx=0, state=FLUSH.
  - fifo_rinc=0 in the flush cycle itself.
- FLUSH: fifo_rinc = !fifo_rempty every cycle; m_valid stays 0; no stall counting.
- FLUSH -> IDLE on the first cycle with fifo_rempty=1.
- flush asserted during FLUSH is ignored.
- frame_count increments on m_valid && m_ready && m_eof. A beat accepted in the same cycle as flush still counts.
- Backpressure: with m_ready=0 and m_valid=1, no pops occur and m_data/m_index/m_sof/m_eof hold stable.
- Asynchronous reset mid-frame returns to the reset state immediately. Partial frame contents in the FIFO are not purged; software issues flush after reset if alignment is required.

Test Plan:
- FRAME_LEN=4, enable=1, FIFO preloaded with 8 words 0x10..0x17, m_ready=1 -> m_valid on 8 consecutive cycles starting 1 cycle after RUN; m_sof on 0x10 and 0x14; m_eof on 0x13 and 0x17; m_index 0,1,2,3,0,1,2,3; frame_count=2.
- Same stimulus, m_ready toggling 1,0 each cycle -> no data loss or duplication; outputs stable while m_ready=0; one pop per accepted beat; frame_count=2.
- FRAME_LEN=4, enable dropped after the 2nd pop with 8 words queued -> 4 words delivered, state IDLE, 4 words remain in the FIFO, busy=0 after the last accept.
- Frame in progress (idx=2), FIFO empty for 5 cycles, then refilled -> stall_count=5; frame completes with correct m_index continuation 2,3.
- flush pulsed with m_valid=1 and 3 words queued -> m_valid=0 next cycle; fifo_rinc high for 3 cycles; then IDLE with idx=0; the next frame starts with m_sof=1.
- rst_n asserted mid-frame -> all outputs 0 immediately without waiting for clk; after release, state IDLE and counters 0.
